// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//
// Auto-play note source for the audio path. Steps through a fixed 16-step,
// two-channel melody at a selectable tempo. Each beat it presents the clock
// dividers for the current step on note_div_left / note_div_right, which drive
// the speaker stage directly. Debounced button levels control transport.
//
// Parameters
//   CLK_HZ       system clock frequency; divider = CLK_HZ / note_freq
//   BEAT_CYCLES  beat period at tempo 0, in clk cycles
//   GAP_CYCLES   silent articulation tail at the end of every beat
//                (must be smaller than BEAT_CYCLES >> 3)
//
// Ports
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   play_btn       in   debounced level, rising edge = play/pause toggle
//   stop_btn       in   debounced level, rising edge = stop
//   next_btn       in   debounced level, rising edge = step +1
//   prev_btn       in   debounced level, rising edge = step -1
//   tempo[1:0]     in   beat period = BEAT_CYCLES >> tempo, taken at beat start
//   loop           in   1 = wrap after step 15, 0 = stop after step 15
//   note_div_left  out  left-channel divider (22'd1 = silence)
//   note_div_right out  right-channel divider (22'd1 = silence)
//   step_idx[3:0]  out  current step
//   playing        out  high while in PLAY
// -----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play_btn,
    input  logic        stop_btn,
    input  logic        next_btn,
    input  logic        prev_btn,
    input  logic [1:0]  tempo,
    input  logic        loop,
    output logic [21:0] note_div_left,
    output logic [21:0] note_div_right,
    output logic [3:0]  step_idx,
    output logic        playing
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [24:0] BEAT_P = 25'(BEAT_CYCLES);
    localparam logic [24:0] GAP_P  = 25'(GAP_CYCLES);
    localparam logic [21:0] SILENT = 22'd1;

    // -------------------------------------------------------------------------
    // Note helpers
    // -------------------------------------------------------------------------

    // Divider for a 4-bit note code; codes 0 and 15 are rests.
    function automatic logic [21:0] note_div(input logic [3:0] code);
        int freq;
        case (code)
            4'd1:    freq = 262;
            4'd2:    freq = 294;
            4'd3:    freq = 330;
            4'd4:    freq = 349;
            4'd5:    freq = 392;
            4'd6:    freq = 440;
            4'd7:    freq = 494;
            4'd8:    freq = 524;
            4'd9:    freq = 588;
            4'd10:   freq = 660;
            4'd11:   freq = 698;
            4'd12:   freq = 784;
            4'd13:   freq = 880;
            4'd14:   freq = 988;
            default: freq = 0;
        endcase
        if (freq == 0) begin
            return SILENT;
        end else begin
            return 22'(CLK_HZ / freq);
        end
    endfunction

    // Right-channel melody ROM.
    function automatic logic [3:0] rom_right(input logic [3:0] step);
        case (step)
            4'd0:    return 4'd8;
            4'd1:    return 4'd8;
            4'd2:    return 4'd12;
            4'd3:    return 4'd12;
            4'd4:    return 4'd13;
            4'd5:    return 4'd13;
            4'd6:    return 4'd12;
            4'd7:    return 4'd0;
            4'd8:    return 4'd11;
            4'd9:    return 4'd11;
            4'd10:   return 4'd10;
            4'd11:   return 4'd10;
            4'd12:   return 4'd9;
            4'd13:   return 4'd9;
            4'd14:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Left-channel melody ROM: C4 drone, rest, G4 drone, rest.
    function automatic logic [3:0] rom_left(input logic [3:0] step);
        if (step < 4'd7) begin
            return 4'd1;
        end else if (step == 4'd7) begin
            return 4'd0;
        end else if (step < 4'd15) begin
            return 4'd5;
        end else begin
            return 4'd0;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Button synchronizers and edge detectors
    // -------------------------------------------------------------------------
    logic [3:0] btn_raw_s;
    logic [3:0] btn_s1_r;
    logic [3:0] btn_s2_r;
    logic [3:0] btn_d_r;
    logic [3:0] armed_r;
    logic [1:0] settle_r;
    logic [3:0] btn_edge_s;

    assign btn_raw_s = {prev_btn, next_btn, stop_btn, play_btn};

    // Two-flop synchronizer plus delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_r <= 4'd0;
            btn_s2_r <= 4'd0;
            btn_d_r  <= 4'd0;
        end else begin
            btn_s1_r <= btn_raw_s;
            btn_s2_r <= btn_s1_r;
            btn_d_r  <= btn_s2_r;
        end
    end

    // A button only becomes armed once its synchronized level has been seen
    // low after reset; settle_r waits until btn_s2_r reflects real input, so a
    // button held through reset cannot fake a rising edge on release of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= 2'd0;
            armed_r  <= 4'd0;
        end else begin
            settle_r <= {settle_r[0], 1'b1};
            if (settle_r[1]) begin
                armed_r <= armed_r | ~btn_s2_r;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    assign btn_edge_s = btn_s2_r & ~btn_d_r & armed_r;

    logic play_e_s;
    logic stop_e_s;
    logic fwd_e_s;
    logic back_e_s;

    assign play_e_s = btn_edge_s[0];
    assign stop_e_s = btn_edge_s[1];
    // Simultaneous next and prev cancel each other.
    assign fwd_e_s  = btn_edge_s[2] & ~btn_edge_s[3];
    assign back_e_s = btn_edge_s[3] & ~btn_edge_s[2];

    // -------------------------------------------------------------------------
    // Transport FSM, step and beat counter
    // -------------------------------------------------------------------------
    state_t      state_r;
    state_t      state_n;
    logic [3:0]  step_r;
    logic [3:0]  step_n;
    logic [24:0] cnt_r;
    logic [24:0] cnt_n;
    logic [24:0] period_r;
    logic [24:0] period_n;
    logic        playing_r;

    logic [24:0] tempo_period_s;
    logic        terminal_s;
    logic        nav_s;
    logic        song_end_s;

    assign tempo_period_s = BEAT_P >> tempo;
    assign terminal_s     = (cnt_r == (period_r - 25'd1));
    assign nav_s          = fwd_e_s | back_e_s;
    // Last beat of a non-looping song ends playback; navigation wins over it.
    assign song_end_s     = ~nav_s & terminal_s & (step_r == 4'd15) & ~loop;

    // FSM state, step, counter and period registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            step_r    <= 4'd0;
            cnt_r     <= 25'd0;
            period_r  <= BEAT_P;
            playing_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            step_r    <= step_n;
            cnt_r     <= cnt_n;
            period_r  <= period_n;
            playing_r <= (state_n == ST_PLAY);
        end
    end

    // Next-state logic. The period is re-latched from tempo every time the
    // counter reloads to zero, so a tempo change never shortens a running beat.
    always_comb begin
        state_n  = state_r;
        step_n   = step_r;
        cnt_n    = cnt_r;
        period_n = period_r;
        if (stop_e_s) begin
            state_n  = ST_IDLE;
            step_n   = 4'd0;
            cnt_n    = 25'd0;
            period_n = tempo_period_s;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (play_e_s) begin
                        state_n  = ST_PLAY;
                        cnt_n    = 25'd0;
                        period_n = tempo_period_s;
                    end else begin
                        state_n  = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    // The counter keeps running on the cycle of a pause
                    // press, so PLAY cycles per beat always equal the period.
                    if (nav_s) begin
                        step_n   = fwd_e_s ? (step_r + 4'd1) : (step_r - 4'd1);
                        cnt_n    = 25'd0;
                        period_n = tempo_period_s;
                    end else if (terminal_s) begin
                        step_n   = song_end_s ? 4'd0 : (step_r + 4'd1);
                        cnt_n    = 25'd0;
                        period_n = tempo_period_s;
                    end else begin
                        cnt_n    = cnt_r + 25'd1;
                    end
                    if (song_end_s) begin
                        state_n = ST_IDLE;
                    end else if (play_e_s) begin
                        state_n = ST_PAUSE;
                    end else begin
                        state_n = ST_PLAY;
                    end
                end
                ST_PAUSE: begin
                    if (play_e_s) begin
                        state_n = ST_PLAY;
                    end else begin
                        state_n = ST_PAUSE;
                    end
                    if (nav_s) begin
                        step_n   = fwd_e_s ? (step_r + 4'd1) : (step_r - 4'd1);
                        cnt_n    = 25'd0;
                        period_n = tempo_period_s;
                    end else begin
                        step_n   = step_r;
                    end
                end
                default: begin
                    state_n  = ST_IDLE;
                    step_n   = 4'd0;
                    cnt_n    = 25'd0;
                    period_n = tempo_period_s;
                end
            endcase
        end
    end

    assign step_idx = step_r;
    assign playing  = playing_r;

    // -------------------------------------------------------------------------
    // Note outputs (registered ROM lookup, one cycle behind step/state)
    // -------------------------------------------------------------------------
    logic        audible_s;
    logic [21:0] div_left_s;
    logic [21:0] div_right_s;

    assign audible_s = (state_r == ST_PLAY) && (cnt_r < (period_r - GAP_P));

    // Select the ROM dividers during the sounding part of a PLAY beat.
    always_comb begin
        div_left_s  = SILENT;
        div_right_s = SILENT;
        if (audible_s) begin
            div_left_s  = note_div(rom_left(step_r));
            div_right_s = note_div(rom_right(step_r));
        end else begin
            div_left_s  = SILENT;
            div_right_s = SILENT;
        end
    end

    // Output divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_div_left  <= SILENT;
            note_div_right <= SILENT;
        end else begin
            note_div_left  <= div_left_s;
            note_div_right <= div_right_s;
        end
    end

endmodule
